writeback_sequencer: RTL and testbench
======================================

Name: writeback_sequencer

Overview:
- Result end of the execute stage. Accepts one completed operation at a time: functype, the 256-bit result or store data, the effective address, and the destination register indices.
- Routes the result to the vector register file, the scalar register file, or memory.
- VLD and VST become 16 sequential 16-bit memory transactions. All other ops retire in one cycle.
- Holds off new issue with `ready` while a sequence is in flight.

Parameters:
- LANES, 16, vector lanes per vector register.
- LANE_W, 16, bits per lane and per memory word.
- ADDR_W, 16, memory address width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  op valid from execute; accepted only when ready=1
- functype  in  4  op code: VADD=0, VDOT=1, SMUL=2, SST=3, VLD=4, VST=5, SLL=6, SLH=7, NOP=15
- result  in  LANES*LANE_W  ALU result, or store data for VST/SST
- addr  in  ADDR_W  effective address (base+offset, computed upstream)
- vdst  in  3  vector destination index
- sdst  in  3  scalar destination index
- ready  out  1  idle, can accept start
- done  out  1  one-cycle retire pulse
- vwe  out  1  vector RF write enable
- vwaddr  out  3  vector RF write index
- vwdata  out  LANES*LANE_W  vector RF write data
- swe  out  1  scalar RF write enable
- swaddr  out  3  scalar RF write index
- swdata  out  LANE_W  scalar RF write data
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  LANE_W  memory write data
- mem_we  out  1  memory write strobe
- mem_re  out  1  memory read strobe
- mem_rdata  in  LANE_W  read data, valid exactly 1 cycle after mem_re
- stall_cnt  out  16  busy-cycle counter (see Optional Feature)

Behaviour:
- Reset: state IDLE, ready=1, all other outputs 0, lane counter 0, buffers 0.
- A reset asserted mid-sequence aborts it. From the next edge there are no further mem_we, mem_re or vwe, and no done.
- States: IDLE, SINGLE, STORE, LOAD, LOAD_FIN.
- ready=1 only in IDLE. A start while ready=0 is ignored. Inputs are latched on acceptance, so upstream may change them afterwards.
- Single-cycle ops go IDLE -> SINGLE -> IDLE. All outputs below appear in the cycle after accept, for one cycle, together with done:
  - VADD, SMUL: vwe=1, vwaddr=vdst, vwdata=result.
  - VDOT, SLL, SLH: swe=1, swaddr=sdst, swdata=result[15:0].
  - SST: mem_we=1, mem_addr=addr, mem_wdata=result[15:0].
  - NOP and undefined codes: done only.
- VST goes IDLE -> STORE for 16 cycles -> IDLE.
  - On store cycle i (i=0..15): mem_we=1, mem_addr=addr+i, mem_wdata=lane i = result[16i+15:16i].
  - done is asserted with the i=15 write.
- VLD goes IDLE -> LOAD for 16 cycles -> LOAD_FIN -> IDLE.
  - On load cycle i: mem_re=1, mem_addr=addr+i.
  - The mem_rdata returned one cycle later is captured into lane i of a 256-bit buffer.
  - In LOAD_FIN, after the last capture: vwe=1, vwaddr=vdst, vwdata=buffer, done=1.
  - Total latency is 18 cycles from accept.
- Address arithmetic is modulo 2^ADDR_W; 0xFFFF+1 wraps to 0x0000.
- Memory outputs are 0 whenever their strobe is low.
- done and ready never both assert. The first new accept is possible the cycle after done.

Optional Feature:
- Macro WB_STALL_CNT_EN.
- Defined: stall_cnt increments on each clock while ready=0, saturates at 0xFFFF, and clears on rst.
- Undefined: stall_cnt is tied to 0 and no counter logic is built.

Decomposition:
- Package cvp14_pkg holds:
  - functype localparams (VADD..NOP);
  - LANES, LANE_W, ADDR_W;
  - the state enum.
- One natural sub-module, lane_buffer: a 256-bit buffer with per-lane load-by-index (used by VLD capture) and per-lane select (used by VST output).
- The FSM and address counter stay in the top module.

Test Plan:
- VADD, vdst=3, result=all lanes 0x0001 -> next cycle vwe=1, vwaddr=3, vwdata matches, done=1, ready returns 1 the following cycle.
- SLL, sdst=5, result[15:0]=0x00AB -> swe=1, swaddr=5, swdata=0x00AB for exactly one cycle; no vwe, no mem_we.
- VST, addr=0x0100, lane i=0x1000+i -> 16 consecutive mem_we at 0x0100..0x010F with data 0x1000..0x100F; done on the 16th; start pulses during this window are ignored.
- VLD, addr=0xFFF8, memory model returns addr^0x5A5A -> addresses wrap 0xFFF8..0x0007; at cycle 18 vwe=1 with lane i = (0xFFF8+i)^0x5A5A.
- Reset asserted at store cycle 7 of a VST -> no mem_we after that edge, no done, ready=1, all outputs 0.
- WB_STALL_CNT_EN defined, one VLD then one VADD -> stall_cnt=18 (17 busy cycles for the VLD, 1 for the VADD); undefined -> stall_cnt stays 0.

Source files
------------

// File: rtl/cvp14_pkg.sv
// Shared definitions for the writeback sequencer: datapath geometry,
// functype op codes and the sequencer state encoding.
package cvp14_pkg;

    localparam int unsigned LANES  = 16;
    localparam int unsigned LANE_W = 16;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned VEC_W  = LANES * LANE_W;
    localparam int unsigned CNT_W  = $clog2(LANES);

    localparam logic [3:0] VADD = 4'd0;
    localparam logic [3:0] VDOT = 4'd1;
    localparam logic [3:0] SMUL = 4'd2;
    localparam logic [3:0] SST  = 4'd3;
    localparam logic [3:0] VLD  = 4'd4;
    localparam logic [3:0] VST  = 4'd5;
    localparam logic [3:0] SLL  = 4'd6;
    localparam logic [3:0] SLH  = 4'd7;
    localparam logic [3:0] NOP  = 4'd15;

    typedef enum logic [2:0] {
        IDLE,
        SINGLE,
        STORE,
        LOAD,
        LOAD_FIN
    } wb_state_t;

endpackage

// File: rtl/lane_buffer.sv
// Lane-organised vector buffer: whole-vector load, per-lane write by index
// (load capture) and per-lane read select (store streaming).
module lane_buffer #(
    parameter int unsigned N_LANES = 16,
    parameter int unsigned W       = 16,
    localparam int unsigned IDX_W  = $clog2(N_LANES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_all,
    input  logic [N_LANES*W-1:0] load_data,
    input  logic                 lane_we,
    input  logic [IDX_W-1:0]     lane_idx,
    input  logic [W-1:0]         lane_data,
    input  logic [IDX_W-1:0]     sel_idx,
    output logic [W-1:0]         sel_data,
    output logic [N_LANES*W-1:0] q
);

    logic [N_LANES-1:0][W-1:0] lanes_q;

    // Buffer storage; a whole-vector load takes priority over a lane write.
    always_ff @(posedge clk) begin
        if (rst) begin
            lanes_q <= '0;
        end else if (load_all) begin
            lanes_q <= load_data;
        end else if (lane_we) begin
            lanes_q[lane_idx] <= lane_data;
        end
    end

    assign sel_data = lanes_q[sel_idx];
    assign q        = lanes_q;

endmodule

// File: rtl/writeback_sequencer.sv
// Writeback sequencer: retires one execute-stage op at a time into the
// vector RF, scalar RF or memory; VLD/VST run as 16 lane transactions.
// Optional build macro: WB_STALL_CNT_EN enables the busy-cycle counter.
module writeback_sequencer
    import cvp14_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [3:0]                functype,
    input  logic [LANES*LANE_W-1:0]   result,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [2:0]                vdst,
    input  logic [2:0]                sdst,
    output logic                      ready,
    output logic                      done,
    output logic                      vwe,
    output logic [2:0]                vwaddr,
    output logic [LANES*LANE_W-1:0]   vwdata,
    output logic                      swe,
    output logic [2:0]                swaddr,
    output logic [LANE_W-1:0]         swdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [LANE_W-1:0]         mem_wdata,
    output logic                      mem_we,
    output logic                      mem_re,
    input  logic [LANE_W-1:0]         mem_rdata,
    output logic [15:0]               stall_cnt
);

    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

    wb_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [3:0]         op_q;
    logic [ADDR_W-1:0]  base_q;
    logic [2:0]         vdst_q;
    logic [2:0]         sdst_q;

    logic               accept;
    logic               cap_we;
    logic [CNT_W-1:0]   cap_idx;
    logic [LANE_W-1:0]  sel_data;
    logic [VEC_W-1:0]   buf_q;
    logic [ADDR_W-1:0]  lane_addr;

    assign accept    = (state_q == IDLE) && start;
    assign lane_addr = base_q + ADDR_W'(cnt_q);

    lane_buffer #(
        .N_LANES (LANES),
        .W       (LANE_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .load_all  (accept),
        .load_data (result),
        .lane_we   (cap_we),
        .lane_idx  (cap_idx),
        .lane_data (mem_rdata),
        .sel_idx   (cnt_q),
        .sel_data  (sel_data),
        .q         (buf_q)
    );

    // State register, op latch on accept and lane counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            base_q  <= '0;
            vdst_q  <= '0;
            sdst_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= functype;
                base_q <= addr;
                vdst_q <= vdst;
                sdst_q <= sdst;
                cnt_q  <= '0;
            end else if (state_q == STORE || state_q == LOAD) begin
                cnt_q  <= cnt_q + 1'b1;
            end
        end
    end

    // Next-state decode and all datapath outputs from the registered state.
    always_comb begin
        state_d   = state_q;
        ready     = 1'b0;
        done      = 1'b0;
        vwe       = 1'b0;
        vwaddr    = '0;
        vwdata    = '0;
        swe       = 1'b0;
        swaddr    = '0;
        swdata    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        cap_we    = 1'b0;
        cap_idx   = '0;

        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    case (functype)
                        VST:     state_d = STORE;
                        VLD:     state_d = LOAD;
                        default: state_d = SINGLE;
                    endcase
                end
            end

            SINGLE: begin
                done    = 1'b1;
                state_d = IDLE;
                case (op_q)
                    VADD, SMUL: begin
                        vwe    = 1'b1;
                        vwaddr = vdst_q;
                        vwdata = buf_q;
                    end
                    VDOT, SLL, SLH: begin
                        swe    = 1'b1;
                        swaddr = sdst_q;
                        swdata = buf_q[LANE_W-1:0];
                    end
                    SST: begin
                        mem_we    = 1'b1;
                        mem_addr  = base_q;
                        mem_wdata = buf_q[LANE_W-1:0];
                    end
                    default: ;
                endcase
            end

            STORE: begin
                mem_we    = 1'b1;
                mem_addr  = lane_addr;
                mem_wdata = sel_data;
                if (cnt_q == LAST_LANE) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end

            // Read data trails the read strobe by one cycle, so lane i is
            // captured while lane i+1 is being requested.
            LOAD: begin
                mem_re   = 1'b1;
                mem_addr = lane_addr;
                if (cnt_q != '0) begin
                    cap_we  = 1'b1;
                    cap_idx = cnt_q - 1'b1;
                end
                if (cnt_q == LAST_LANE) begin
                    state_d = LOAD_FIN;
                end
            end

            // The last lane is still on mem_rdata here, so it is forwarded
            // straight into the write data instead of waiting another cycle.
            LOAD_FIN: begin
                vwe     = 1'b1;
                vwaddr  = vdst_q;
                vwdata  = {mem_rdata, buf_q[VEC_W-LANE_W-1:0]};
                done    = 1'b1;
                cap_we  = 1'b1;
                cap_idx = LAST_LANE;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

`ifdef WB_STALL_CNT_EN
    logic [15:0] stall_q;

    // Busy-cycle counter: counts every clock spent outside IDLE, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (state_q != IDLE && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_writeback_sequencer.sv
// Self-checking bench for writeback_sequencer: table of single-cycle ops
// plus hand sequences for VST, wrapping VLD, mid-store reset and stall count.
module tb_writeback_sequencer;
    import cvp14_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   functype = 4'hF;
    logic [255:0] result = '0;
    logic [15:0]  addr = '0;
    logic [2:0]   vdst = '0;
    logic [2:0]   sdst = '0;
    logic         ready, done, vwe, swe, mem_we, mem_re;
    logic [2:0]   vwaddr, swaddr;
    logic [255:0] vwdata;
    logic [15:0]  swdata, mem_addr, mem_wdata, stall_cnt;
    logic [15:0]  mem_rdata = '0;

    writeback_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .functype  (functype),
        .result    (result),
        .addr      (addr),
        .vdst      (vdst),
        .sdst      (sdst),
        .ready     (ready),
        .done      (done),
        .vwe       (vwe),
        .vwaddr    (vwaddr),
        .vwdata    (vwdata),
        .swe       (swe),
        .swaddr    (swaddr),
        .swdata    (swdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // Memory model: synchronous read returning address ^ 0x5A5A one cycle later.
    always @(posedge clk) begin
        mem_rdata <= mem_re ? (mem_addr ^ 16'h5A5A) : 16'h0000;
    end

    typedef struct {
        logic [3:0]   ft;
        logic [255:0] res;
        logic [15:0]  addr;
        logic [2:0]   vdst;
        logic [2:0]   sdst;
        logic         ev;
        logic         es;
        logic         em;
    } vec_t;

    typedef struct { logic [2:0] idx; logic [255:0] data; } vexp_t;
    typedef struct { logic [2:0] idx; logic [15:0] data; }  sexp_t;
    typedef struct { logic [15:0] addr; logic [15:0] data; } mexp_t;

    vexp_t       exp_v[$];
    sexp_t       exp_s[$];
    mexp_t       exp_w[$];
    logic [15:0] exp_r[$];

    int n_cmp = 0;
    int n_bad = 0;
    int done_seen = 0;
    int done_exp = 0;
    bit mon_en = 1'b0;

    vec_t tab[9];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] lanes(input logic [15:0] base, input logic [15:0] step);
        logic [255:0] v;
        for (int i = 0; i < 16; i++) v[16*i +: 16] = 16'(base + 16'(step * i));
        return v;
    endfunction

    // Scoreboard monitor: every strobe pops and compares its expected record.
    always @(negedge clk) begin
        vexp_t ve;
        sexp_t se;
        mexp_t me;
        logic [15:0] ra;
        if (mon_en) begin
            if (vwe) begin
                if (exp_v.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL vwe_unexpected: got vwe=1 addr=%0d expected none", vwaddr);
                end else begin
                    ve = exp_v.pop_front();
                    check("vwaddr", 256'(vwaddr), 256'(ve.idx));
                    check("vwdata", vwdata, ve.data);
                end
            end
            if (swe) begin
                if (exp_s.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL swe_unexpected: got swe=1 addr=%0d expected none", swaddr);
                end else begin
                    se = exp_s.pop_front();
                    check("swaddr", 256'(swaddr), 256'(se.idx));
                    check("swdata", 256'(swdata), 256'(se.data));
                end
            end
            if (mem_we) begin
                if (exp_w.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL mem_we_unexpected: got write addr=%0h expected none", mem_addr);
                end else begin
                    me = exp_w.pop_front();
                    check("wr_addr", 256'(mem_addr), 256'(me.addr));
                    check("wr_data", 256'(mem_wdata), 256'(me.data));
                end
            end
            if (mem_re) begin
                if (exp_r.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL mem_re_unexpected: got read addr=%0h expected none", mem_addr);
                end else begin
                    ra = exp_r.pop_front();
                    check("rd_addr", 256'(mem_addr), 256'(ra));
                    check("rd_wdata_zero", 256'(mem_wdata), 256'(0));
                end
            end
            if (!mem_we && !mem_re) check("mem_idle_zero", {mem_addr, mem_wdata}, 256'(0));
            check("done_and_ready", 256'(done & ready), 256'(0));
            if (done) done_seen++;
        end
    end

    task automatic wait_ready();
        bit ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_ready: got ready=0 for 50 cycles expected 1");
        end
    endtask

    task automatic run_row(input vec_t v);
        wait_ready();
        @(posedge clk); #1;
        start = 1'b1; functype = v.ft; result = v.res; addr = v.addr;
        vdst = v.vdst; sdst = v.sdst;
        if (v.ev) exp_v.push_back('{idx: v.vdst, data: v.res});
        if (v.es) exp_s.push_back('{idx: v.sdst, data: v.res[15:0]});
        if (v.em) exp_w.push_back('{addr: v.addr, data: v.res[15:0]});
        done_exp++;
        @(posedge clk); #1;
        start = 1'b0; functype = VADD; result = ~v.res; addr = ~v.addr;
        vdst = ~v.vdst; sdst = ~v.sdst;
        @(negedge clk);
        check("row_strobes", 256'({vwe, swe, mem_we, mem_re, done, ready}),
              256'({v.ev, v.es, v.em, 1'b0, 1'b1, 1'b0}));
        @(negedge clk);
        check("row_after", 256'({vwe, swe, mem_we, done, ready}), 256'(5'b00001));
    endtask

    initial begin
        logic [255:0] vexp;
        logic [255:0] vres;
        int lat;
        bit got;

        tab[0] = '{ft: VADD, res: lanes(16'h0001, 16'h0000), addr: 16'h0000, vdst: 3'd3, sdst: 3'd0, ev: 1, es: 0, em: 0};
        tab[1] = '{ft: SLL,  res: lanes(16'h00AB, 16'h1111), addr: 16'h0000, vdst: 3'd0, sdst: 3'd5, ev: 0, es: 1, em: 0};
        tab[2] = '{ft: VDOT, res: lanes(16'h7F01, 16'h0203), addr: 16'h0000, vdst: 3'd2, sdst: 3'd1, ev: 0, es: 1, em: 0};
        tab[3] = '{ft: SMUL, res: lanes(16'hC000, 16'h0101), addr: 16'h0000, vdst: 3'd7, sdst: 3'd2, ev: 1, es: 0, em: 0};
        tab[4] = '{ft: SST,  res: lanes(16'hBEEF, 16'h0001), addr: 16'h1234, vdst: 3'd1, sdst: 3'd1, ev: 0, es: 0, em: 1};
        tab[5] = '{ft: NOP,  res: lanes(16'hFFFF, 16'h0000), addr: 16'h4321, vdst: 3'd4, sdst: 3'd4, ev: 0, es: 0, em: 0};
        tab[6] = '{ft: SLH,  res: lanes(16'h8001, 16'h0003), addr: 16'h0000, vdst: 3'd5, sdst: 3'd0, ev: 0, es: 1, em: 0};
        tab[7] = '{ft: 4'd9, res: lanes(16'h1357, 16'h2468), addr: 16'h0042, vdst: 3'd6, sdst: 3'd6, ev: 0, es: 0, em: 0};
        tab[8] = '{ft: VADD, res: lanes(16'hA5A5, 16'h0F0F), addr: 16'h0000, vdst: 3'd0, sdst: 3'd3, ev: 1, es: 0, em: 0};

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("reset_ready_done", 256'({ready, done, vwe, swe, mem_we, mem_re}), 256'(6'b100000));
        check("reset_data", {vwdata[63:0], vwaddr, swaddr, swdata, mem_addr, mem_wdata}, 256'(0));
        check("reset_stall", 256'(stall_cnt), 256'(0));

        // VLD across the address wrap
        vexp = '0;
        for (int i = 0; i < 16; i++) begin
            exp_r.push_back(16'(16'hFFF8 + i));
            vexp[16*i +: 16] = 16'(16'hFFF8 + i) ^ 16'h5A5A;
        end
        exp_v.push_back('{idx: 3'd6, data: vexp});
        done_exp++;
        wait_ready();
        @(posedge clk); #1;
        start = 1'b1; functype = VLD; addr = 16'hFFF8; vdst = 3'd6; result = lanes(16'hDEAD, 16'h0001);
        lat = 1; got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            if (k == 0) begin
                #1 start = 1'b0; addr = 16'h0000; vdst = 3'd1;
            end
            lat++;
            @(negedge clk);
            if (vwe) begin got = 1'b1; break; end
        end
        check("vld_latency", got ? 256'(lat) : 256'(0), 256'(18));
        check("vld_done", 256'(done), 256'(1));

        // First table row (VADD), then the busy-cycle count
        run_row(tab[0]);
`ifdef WB_STALL_CNT_EN
        check("stall_cnt", 256'(stall_cnt), 256'(18));
`else
        check("stall_cnt", 256'(stall_cnt), 256'(0));
`endif

        for (int r = 1; r < 9; r++) run_row(tab[r]);

        // VST with ignored start pulses during the burst
        vres = lanes(16'h1000, 16'h0001);
        for (int i = 0; i < 16; i++)
            exp_w.push_back('{addr: 16'(16'h0100 + i), data: 16'(16'h1000 + i)});
        done_exp++;
        wait_ready();
        @(posedge clk); #1;
        start = 1'b1; functype = VST; addr = 16'h0100; result = vres;
        @(posedge clk); #1;
        start = 1'b0; functype = VADD; addr = 16'h7777; result = ~vres;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("vst_cycle", 256'({mem_we, done, ready}), 256'({1'b1, (i == 15), 1'b0}));
            @(posedge clk); #1;
            start = (i < 14) ? i[0] : 1'b0;
        end
        @(negedge clk);
        check("vst_after", 256'({ready, done, mem_we, vwe}), 256'(4'b1000));

        // Reset during store cycle 7 aborts the VST
        for (int i = 0; i < 8; i++)
            exp_w.push_back('{addr: 16'(16'h0200 + i), data: 16'(16'h2000 + i)});
        wait_ready();
        @(posedge clk); #1;
        start = 1'b1; functype = VST; addr = 16'h0200; result = lanes(16'h2000, 16'h0001);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_outputs", 256'({ready, done, vwe, swe, mem_we, mem_re, mem_addr, mem_wdata, vwaddr, swaddr, swdata}),
              256'({1'b1, 59'd0}));
        check("abort_vwdata", vwdata, 256'(0));
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_idle", 256'({ready, mem_we, done}), 256'(3'b100));

        // Scoreboard drained and retire count
        check("exp_v_left", 256'(exp_v.size()), 256'(0));
        check("exp_s_left", 256'(exp_s.size()), 256'(0));
        check("exp_w_left", 256'(exp_w.size()), 256'(0));
        check("exp_r_left", 256'(exp_r.size()), 256'(0));
        check("done_count", 256'(done_seen), 256'(done_exp));
`ifndef WB_STALL_CNT_EN
        check("stall_final", 256'(stall_cnt), 256'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish by 100000 ns expected finish");
        $fatal(1, "timeout");
    end

endmodule
